// File: rtl/branch_unit.sv
// Branch resolution unit: compares operands, computes target/successor PC and
// holds the result in a one-deep output register. Optional BHT via BRANCH_UNIT_PREDICT_EN.
module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            illegal,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken,
    output logic            mispredict
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_q;
    logic            taken_q, illegal_q, pred_q, mispred_q;
    logic [XLEN-1:0] target_q, next_pc_q;

    logic            accept;
    logic            taken_d, illegal_d, pred_d, mispred_d;
    logic [XLEN-1:0] target_d, next_pc_d;

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (funct3)
            3'b000:  taken_d = (rs1_val == rs2_val);
            3'b001:  taken_d = (rs1_val != rs2_val);
            3'b100:  taken_d = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken_d = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken_d = (rs1_val <  rs2_val);
            3'b111:  taken_d = (rs1_val >= rs2_val);
            default: illegal_d = 1'b1;
        endcase
    end

    assign target_d  = pc + imm;
    assign next_pc_d = taken_d ? target_d : pc + XLEN'(4);

`ifdef BRANCH_UNIT_PREDICT_EN
    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      bht_q [BHT_DEPTH];
    logic [IDXW-1:0] idx;
    logic [1:0]      ctr;

    // Counter is read straight from the table, so an update on one edge is
    // visible to an accept on the very next cycle.
    assign idx       = pc[IDXW+1:2];
    assign ctr       = bht_q[idx];
    assign pred_d    = ctr[1];
    assign mispred_d = pred_d != taken_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else if (accept && !illegal_d) begin
            if (taken_d && ctr != 2'b11)       bht_q[idx] <= ctr + 2'b01;
            else if (!taken_d && ctr != 2'b00) bht_q[idx] <= ctr - 2'b01;
        end
    end
`else
    assign pred_d    = 1'b0;
    assign mispred_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= '0;
            next_pc_q <= '0;
            pred_q    <= 1'b0;
            mispred_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_q <= FULL;
                FULL:    if (out_ready && !accept) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                taken_q   <= taken_d;
                illegal_q <= illegal_d;
                target_q  <= target_d;
                next_pc_q <= next_pc_d;
                pred_q    <= pred_d;
                mispred_q <= mispred_d;
            end
        end
    end

    assign out_valid  = (state_q == FULL);
    assign taken      = taken_q;
    assign illegal    = illegal_q;
    assign target     = target_q;
    assign next_pc    = next_pc_q;
    assign pred_taken = pred_q;
    assign mispredict = mispred_q;
endmodule

// File: tb/tb_branch_unit.sv
// Table-driven bench for branch_unit with an expected-result queue and a
// reference predictor model when BRANCH_UNIT_PREDICT_EN is defined.
module tb_branch_unit;
    localparam int XLEN = 32;

    logic            clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val, rs2_val, pc, imm, target, next_pc;
    logic            taken, illegal, pred_taken, mispredict;

    branch_unit #(.XLEN(XLEN), .BHT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .illegal(illegal),
        .target(target), .next_pc(next_pc), .pred_taken(pred_taken), .mispredict(mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a, b, pc, imm;
        logic            taken, illegal;
        logic [XLEN-1:0] npc;
    } vec_t;

    typedef struct {
        logic            taken, illegal;
        logic [XLEN-1:0] target, npc;
        logic            pred, mis;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t drv_exp;
    logic plog_pred[$];
    logic plog_mis[$];
    vec_t vecs[13];
`ifdef BRANCH_UNIT_PREDICT_EN
    logic [1:0] mbht [16];
`endif

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks handshake and result contents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_in_ready", {31'b0, in_ready}, 1);
            q.delete();
`ifdef BRANCH_UNIT_PREDICT_EN
            for (int i = 0; i < 16; i++) mbht[i] = 2'b01;
`endif
        end else begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || out_ready});
            if (out_valid && q.size() != 0) begin
                chk("taken", {31'b0, taken}, {31'b0, q[0].taken});
                chk("illegal", {31'b0, illegal}, {31'b0, q[0].illegal});
                chk("target", target, q[0].target);
                chk("next_pc", next_pc, q[0].npc);
                chk("pred_taken", {31'b0, pred_taken}, {31'b0, q[0].pred});
                chk("mispredict", {31'b0, mispredict}, {31'b0, q[0].mis});
                if (out_ready) begin
                    plog_pred.push_back(q[0].pred);
                    plog_mis.push_back(q[0].mis);
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = drv_exp;
`ifdef BRANCH_UNIT_PREDICT_EN
                begin
                    logic [3:0] ix;
                    logic [1:0] c;
                    ix = pc[5:2];
                    c = mbht[ix];
                    e.pred = c[1];
                    e.mis = e.pred != e.taken;
                    if (!e.illegal) begin
                        if (e.taken && c != 2'b11) mbht[ix] = c + 2'b01;
                        else if (!e.taken && c != 2'b00) mbht[ix] = c - 2'b01;
                    end
                end
`else
                e.pred = 1'b0;
                e.mis = 1'b0;
`endif
                q.push_back(e);
            end
        end
    end

    task automatic send(input vec_t v);
        int budget;
        funct3 = v.f3; rs1_val = v.a; rs2_val = v.b; pc = v.pc; imm = v.imm;
        drv_exp.taken = v.taken; drv_exp.illegal = v.illegal;
        drv_exp.target = v.pc + v.imm; drv_exp.npc = v.npc;
        drv_exp.pred = 1'b0; drv_exp.mis = 1'b0;
        in_valid = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [XLEN-1:0] p, input logic [XLEN-1:0] i, input logic t,
                                input logic il, input logic [XLEN-1:0] n);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.pc = p; v.imm = i; v.taken = t; v.illegal = il; v.npc = n;
        return v;
    endfunction

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 0);
        chk("async_taken", {31'b0, taken}, 0);
        chk("async_target", target, 0);
        chk("async_next_pc", next_pc, 0);
        chk("async_pred", {31'b0, pred_taken}, 0);
        chk("async_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(3'b100, 32'd8, 32'd8, 32'h100, 32'd8, 0, 0, 32'h104);
        vecs[1]  = mk(3'b100, 32'hFFFF_FFFF, 32'd8, 32'h200, 32'h10, 1, 0, 32'h210);
        vecs[2]  = mk(3'b110, 32'hFFFF_FFFF, 32'd8, 32'h200, 32'h10, 0, 0, 32'h204);
        vecs[3]  = mk(3'b000, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1, 0, 32'h4);
        vecs[4]  = mk(3'b001, 32'd5, 32'd5, 32'h300, 32'hFFFF_FFFC, 0, 0, 32'h304);
        vecs[5]  = mk(3'b001, 32'd1, 32'd2, 32'h300, 32'hFFFF_FFFC, 1, 0, 32'h2FC);
        vecs[6]  = mk(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h400, 32'h20, 0, 0, 32'h404);
        vecs[7]  = mk(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h400, 32'h20, 1, 0, 32'h420);
        vecs[8]  = mk(3'b101, 32'd5, 32'd5, 32'h40, 32'h100, 1, 0, 32'h140);
        vecs[9]  = mk(3'b010, 32'd1, 32'd1, 32'h500, 32'd8, 0, 1, 32'h504);
        vecs[10] = mk(3'b011, 32'd0, 32'd1, 32'hFFFF_FFFC, 32'd8, 0, 1, 32'h0);
        vecs[11] = mk(3'b111, 32'd3, 32'd4, 32'h600, 32'd8, 0, 0, 32'h604);
        vecs[12] = mk(3'b110, 32'd3, 32'd4, 32'h600, 32'd8, 1, 0, 32'h608);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; rs1_val = '0; rs2_val = '0; pc = '0; imm = '0;
        drv_exp = '{default: '0};
        #2;
        chk("reset_out_valid", {31'b0, out_valid}, 0);
        chk("reset_illegal", {31'b0, illegal}, 0);
        chk("reset_mispredict", {31'b0, mispredict}, 0);
        chk("reset_in_ready", {31'b0, in_ready}, 1);
        #10; rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back table sweep
        for (int i = 0; i < 13; i++) send(vecs[i]);
        repeat (3) @(posedge clk); #1;

        // Stall for 3 cycles with a second request waiting, then drain+accept
        out_ready = 1'b0;
        send(vecs[1]);
        fork
            send(vecs[0]);
            begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
        join
        send(vecs[3]);
        send(vecs[10]);
        repeat (3) @(posedge clk); #1;

        // Predictor training on one pc from a fresh table
        pulse_reset();
        @(posedge clk); #1;
        plog_pred.delete(); plog_mis.delete();
        for (int i = 0; i < 5; i++) send(mk(3'b101, 32'd9, 32'd5, 32'h80, 32'h40, 1, 0, 32'hC0));
        send(mk(3'b010, 32'd9, 32'd5, 32'h80, 32'h40, 0, 1, 32'h84));
        for (int i = 0; i < 4; i++) send(mk(3'b100, 32'd8, 32'd8, 32'h80, 32'h40, 0, 0, 32'h84));
        for (int i = 0; i < 3; i++) send(mk(3'b101, 32'd5, 32'd5, 32'h80, 32'h40, 1, 0, 32'hC0));
        repeat (2) @(posedge clk); #1;
        chk("plog_len", plog_pred.size(), 13);
        begin
            logic [3:0] exp_p, exp_m, got_p, got_m;
`ifdef BRANCH_UNIT_PREDICT_EN
            exp_p = 4'b1110; exp_m = 4'b0001;
`else
            exp_p = 4'b0000; exp_m = 4'b0000;
`endif
            got_p = 4'b0; got_m = 4'b0;
            for (int i = 0; i < 4 && i < plog_pred.size(); i++) begin
                got_p[i] = plog_pred[i];
                got_m[i] = plog_mis[i];
            end
            chk("pred_seq", {28'b0, got_p}, {28'b0, exp_p});
            chk("mis_seq", {28'b0, got_m}, {28'b0, exp_m});
        end

        // Reset mid-stall discards the pending result
        out_ready = 1'b0;
        send(vecs[5]);
        @(posedge clk); #1;
        pulse_reset();
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[7]);
        repeat (3) @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand, PC, immediate and target width.
REQ-002 Parameter BHT_DEPTH, default 16, power of two >= 2, SHALL set predictor table entries.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL flag a branch request.
REQ-006 in_ready  output  1  SHALL flag that the unit accepts a request this cycle.
REQ-007 funct3  input  3  SHALL carry the branch condition code.
REQ-008 rs1_val, rs2_val  input  XLEN  SHALL carry the comparison operands.
REQ-009 pc, imm  input  XLEN  SHALL carry the branch PC and the sign-extended byte offset.
REQ-010 out_valid  output  1  SHALL flag a resolved result held in the output register.
REQ-011 out_ready  input  1  SHALL flag that the consumer takes the result.
REQ-012 taken, illegal  output  1 each  SHALL carry the resolved outcome and the unsupported-funct3 flag.
REQ-013 target, next_pc  output  XLEN each  SHALL carry pc+imm and the resolved successor PC.
REQ-014 pred_taken, mispredict  output  1 each  SHALL carry the prediction and the prediction-error flag.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready.
REQ-016 The result of an accepted request SHALL appear on the outputs with out_valid=1 exactly one cycle after accept.
REQ-017 funct3 decode SHALL be: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
REQ-018 funct3 010/011 SHALL produce illegal=1, taken=0, next_pc=pc+4.
REQ-019 target SHALL be pc+imm and next_pc SHALL be taken ? target : pc+4, both modulo 2^XLEN (wrap-around, no overflow flag).
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-021 Drain and accept in the same cycle SHALL replace the output register with the new result, out_valid remaining 1.
REQ-022 Drain without accept SHALL clear out_valid on the next edge; other outputs MAY hold stale values.
REQ-023 Output register state machine SHALL be EMPTY -> FULL on accept, FULL -> EMPTY on drain without accept, and FULL -> FULL on stall or on drain with accept.

Reset
REQ-024 Reset SHALL force out_valid=0, taken=0, illegal=0, target=0, next_pc=0, pred_taken=0 and mispredict=0 immediately, without waiting for clk.
REQ-025 Reset asserted with out_valid=1 SHALL discard the pending result; no result SHALL reappear after release.
REQ-026 Reset SHALL initialise every predictor counter to 2'b01 (weakly not-taken) when the predictor is compiled in.
REQ-027 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-028 Macro BRANCH_UNIT_PREDICT_EN, when defined, SHALL compile in a BHT of BHT_DEPTH 2-bit saturating counters indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-029 With the predictor compiled in, pred_taken SHALL be counter[1] as read at accept, and mispredict SHALL be pred_taken != taken, registered with the result.
REQ-030 With the predictor compiled in, the indexed counter SHALL update on the accept edge: increment if taken, decrement if not, saturating at 0 and 3, and never on illegal.
REQ-031 With the predictor compiled in, an accept on the cycle after an update to the same index SHALL read the updated counter.
REQ-032 Without the macro, pred_taken and mispredict SHALL be tied to 0 and no table storage SHALL exist.

Verification
REQ-033 BLT rs1=8, rs2=8, pc=0x100, imm=8 -> taken=0, next_pc=0x104, one cycle after accept.
REQ-034 BLT rs1=-1 (0xFFFFFFFF), rs2=8 -> taken=1, next_pc=pc+imm; BLTU with the same operands -> taken=0.
REQ-035 pc=0xFFFFFFFC, imm=8, BEQ rs1=rs2=5 -> taken=1, target=0x00000004 (wrap-around).
REQ-036 out_ready=0 for 3 cycles after a result -> outputs stable and in_ready=0 throughout; out_ready=1 with in_valid=1 -> back-to-back results, with no gap and no drop.
REQ-037 With BRANCH_UNIT_PREDICT_EN, four taken BGE at the same pc -> pred_taken sequence 0,1,1,1, mispredict 1,0,0,0, and the counter saturates at 3.
REQ-038 rst pulsed while out_valid=1 mid-stall -> out_valid=0 immediately, no result after release, and in_ready=1.
